// File: rtl/inst_rom.sv
// -----------------------------------------------------------------------------
// inst_rom -- instruction memory for the OpenMIPS fetch port, with a
// byte-serial program loader.
//
// Fetch side (combinational, zero latency):
//   rom_en    in   fetch enable from the core
//   rom_addr  in   byte address; word index = rom_addr[ADDR_WIDTH+1:2],
//                  all other bits ignored (aliasing)
//   rom_data  out  instruction word, 0 when disabled, loading or in reset
//
// Loader side (valid/ready, one byte per cycle, big-endian packing):
//   ld_start  in   begin/restart a load at ld_base (priority over bytes)
//   ld_base   in   starting word index
//   ld_valid  in   ld_byte is valid
//   ld_byte   in   program byte, first byte of a word lands in bits 31:24
//   ld_last   in   marks the final byte of the image
//   ld_ready  out  loader accepts a byte this cycle (LOAD or DRAIN)
//   ld_busy   out  loader not IDLE (fetch returns 0 meanwhile)
//   ld_count  out  words written since the last ld_start
//   ld_err    out  sticky: image ran past the top word; cleared by ld_start
//
// clk / reset: single rising-edge clock, synchronous active-high reset.
// The memory array itself is never cleared by reset.
// -----------------------------------------------------------------------------
module inst_rom #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rom_en,
    input  logic [31:0]           rom_addr,
    output logic [31:0]           rom_data,
    input  logic                  ld_start,
    input  logic [ADDR_WIDTH-1:0] ld_base,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic [ADDR_WIDTH:0]   ld_count,
    output logic                  ld_err
);

    localparam int                    DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TOP_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    logic [31:0]           mem [DEPTH];

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [1:0]            idx_q;
    logic [31:0]           asm_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  err_q;
    logic                  busy_q;
    logic                  ready_q;

    logic [31:0]           word_d;
    logic                  wr_en;

    // Insert the incoming byte into lane (3 - idx); lanes not yet filled
    // stay zero because the assembly register is cleared after every write.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_d[gi*8 +: 8] = (idx_q == 2'(3 - gi)) ? ld_byte
                                                             : asm_q[gi*8 +: 8];
        end
    endgenerate

    // A word is committed when its fourth byte or the final image byte is
    // accepted. ld_start wins over any byte presented in the same cycle.
    assign wr_en = (state_q == ST_LOAD) && ld_valid && !ld_start && !reset &&
                   ((idx_q == 2'd3) || ld_last);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            idx_q   <= 2'd0;
            asm_q   <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else if (ld_start) begin
            // Restart is identical from every state; partial word discarded.
            state_q <= ST_LOAD;
            wptr_q  <= ld_base;
            idx_q   <= 2'd0;
            asm_q   <= 32'h0;
            count_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (ld_valid) begin
                        if ((idx_q == 2'd3) || ld_last) begin
                            count_q <= count_q + 1'b1;
                            idx_q   <= 2'd0;
                            asm_q   <= 32'h0;
                            if (ld_last) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b0;
                            end else if (wptr_q == TOP_IDX) begin
                                // Image continues past the top word: swallow
                                // the rest without writing anything.
                                err_q   <= 1'b1;
                                state_q <= ST_DRAIN;
                            end else begin
                                wptr_q <= wptr_q + 1'b1;
                            end
                        end else begin
                            asm_q <= word_d;
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ld_valid && ld_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ld_ready = ready_q;
    assign ld_busy  = busy_q;
    assign ld_count = count_q;
    assign ld_err   = err_q;

    // Fetch is gated off while the loader owns the memory and during reset.
    assign rom_data = (rom_en && !busy_q && !reset) ? mem[rom_addr[ADDR_WIDTH+1:2]]
                                                    : 32'h0;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr[31:ADDR_WIDTH+2], rom_addr[1:0]};

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        ld_start;
    logic [9:0]  ld_base;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;

    // Two instances share the stimulus: default depth and a 4-word one
    // (the latter sees ld_base[1:0]) to exercise overflow.
    logic [31:0] rd_b, rd_s;
    logic        rdy_b, rdy_s, busy_b, busy_s, err_b, err_s;
    logic [10:0] cnt_b;
    logic [2:0]  cnt_s;

    inst_rom #(.ADDR_WIDTH(10)) dut_b (
        .clk(clk), .reset(reset), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rd_b), .ld_start(ld_start), .ld_base(ld_base),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(rdy_b), .ld_busy(busy_b), .ld_count(cnt_b), .ld_err(err_b)
    );

    inst_rom #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rd_s), .ld_start(ld_start), .ld_base(ld_base[1:0]),
        .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(rdy_s), .ld_busy(busy_s), .ld_count(cnt_s), .ld_err(err_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents known to be written, plus the
    // expected count/err of the most recent completed load.
    logic [31:0] mb [1024];
    bit          vb [1024];
    logic [31:0] ms [4];
    bit          vs [4];
    int          mcnt_b, mcnt_s;
    bit          merr_b, merr_s;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] exp_b;
        logic [31:0] exp_s;
    } fvec_t;
    fvec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word k of an image: bytes 4k..4k+3, big-endian, missing bytes zero.
    function automatic logic [31:0] img_word(input logic [7:0] d[$], input int k);
        logic [31:0] w = 32'h0;
        for (int j = 0; j < 4; j++)
            if (4*k + j < d.size())
                w = w | (32'(d[4*k + j]) << (24 - 8*j));
        return w;
    endfunction

    // Whole-image effect of a completed load on a memory of a given depth.
    task automatic model_load(input int base, input logic [7:0] d[$]);
        int nw = (d.size() + 3) / 4;
        int bs = base % 4;
        mcnt_b = 0;
        for (int k = 0; k < nw && base + k < 1024; k++) begin
            mb[base + k] = img_word(d, k);
            vb[base + k] = 1'b1;
            mcnt_b++;
        end
        merr_b = (nw > 1024 - base);
        mcnt_s = 0;
        for (int k = 0; k < nw && bs + k < 4; k++) begin
            ms[bs + k] = img_word(d, k);
            vs[bs + k] = 1'b1;
            mcnt_s++;
        end
        merr_s = (nw > 4 - bs);
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] addr);
        int ib = int'(addr[11:2]);
        int is_ = int'(addr[3:2]);
        rom_en   = 1'b1;
        rom_addr = addr;
        #1;
        if (vb[ib]) chk({name, "_b"}, rd_b, mb[ib]);
        if (vs[is_]) chk({name, "_s"}, rd_s, ms[is_]);
    endtask

    task automatic do_start(input int base);
        ld_start = 1'b1;
        ld_base  = 10'(base);
        ld_valid = 1'b0;
        step();
        ld_start = 1'b0;
        chk("start_busy_b", busy_b, 1'b1);
        chk("start_ready_s", rdy_s, 1'b1);
        chk("start_cnt_b", cnt_b, 0);
        chk("start_err_s", err_s, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        ld_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic check_done(input string name);
        chk({name, "_busy_b"}, busy_b, 1'b0);
        chk({name, "_ready_s"}, rdy_s, 1'b0);
        chk({name, "_cnt_b"}, cnt_b, mcnt_b);
        chk({name, "_cnt_s"}, cnt_s, mcnt_s);
        chk({name, "_err_b"}, err_b, merr_b);
        chk({name, "_err_s"}, err_s, merr_s);
    endtask

    task automatic do_load(input string name, input int base, input logic [7:0] d[$], input int maxgap);
        do_start(base);
        for (int i = 0; i < d.size(); i++)
            send_byte(d[i], i == d.size() - 1, $urandom_range(0, maxgap));
        model_load(base, d);
        $display("LOAD %s base=%0d bytes=%0d words_b=%0d err_s=%0d", name, base, d.size(), mcnt_b, merr_s);
        check_done(name);
    endtask

    initial begin
        logic [7:0] q[$];

        tbl[0] = '{1'b1, 32'h0000_0000, 32'h3C01_0101, 32'h3C01_0101};
        tbl[1] = '{1'b1, 32'h0000_0004, 32'h3421_0020, 32'h3421_0020};
        tbl[2] = '{1'b1, 32'h0000_0006, 32'h3421_0020, 32'h3421_0020};
        tbl[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000};
        tbl[4] = '{1'b1, 32'hFFFF_F004, 32'h3421_0020, 32'h3421_0020};
        tbl[5] = '{1'b1, 32'h0000_1001, 32'h3C01_0101, 32'h3C01_0101};

        for (int i = 0; i < 1024; i++) vb[i] = 1'b0;
        for (int i = 0; i < 4; i++) vs[i] = 1'b0;

        reset = 1'b1; rom_en = 1'b1; rom_addr = 32'h0;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;

        // Reset state
        step(); step();
        chk("rst_data_b", rd_b, 32'h0);
        chk("rst_data_s", rd_s, 32'h0);
        chk("rst_ready_b", rdy_b, 1'b0);
        chk("rst_busy_s", busy_s, 1'b0);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_err_b", err_b, 1'b0);
        reset = 1'b0;
        step();

        // Full-word load, then table-driven fetches
        q = {8'h3C, 8'h01, 8'h01, 8'h01, 8'h34, 8'h21, 8'h00, 8'h20};
        do_load("full", 0, q, 0);
        chk("full_cnt_const", cnt_b, 2);
        for (int i = 0; i < 6; i++) begin
            rom_en = tbl[i].en;
            rom_addr = tbl[i].addr;
            #1;
            chk($sformatf("tbl%0d_b", i), rd_b, tbl[i].exp_b);
            chk($sformatf("tbl%0d_s", i), rd_s, tbl[i].exp_s);
            $display("FETCH en=%0d addr=%08h data_b=%08h data_s=%08h", tbl[i].en, tbl[i].addr, rd_b, rd_s);
        end
        rom_en = 1'b1;

        // Memory survives reset
        reset = 1'b1; rom_addr = 32'h0;
        #1;
        chk("rst2_data_gated", rd_b, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("rst2_survive_b", rd_b, 32'h3C01_0101);
        chk("rst2_survive_s", rd_s, 32'h3C01_0101);

        // Partial word with gaps
        q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        do_load("partial", 1, q, 2);
        fetch_chk("partial_m1", 32'h4);
        fetch_chk("partial_m2", 32'h8);
        chk("partial_m2_const", rd_b, 32'hEEFF_0000);
        chk("partial_cnt_const", cnt_b, 2);

        // Overflow on the 4-word instance
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_start(3);
        for (int i = 0; i < 8; i++) begin
            send_byte(q[i], i == 7, 0);
            if (i == 3) begin
                chk("ovf_err_rise_s", err_s, 1'b1);
                chk("ovf_drain_ready_s", rdy_s, 1'b1);
                chk("ovf_drain_busy_s", busy_s, 1'b1);
                chk("ovf_cnt_mid_s", cnt_s, 1);
                chk("ovf_err_b", err_b, 1'b0);
            end
        end
        model_load(3, q);
        $display("LOAD overflow base=3 bytes=8 words_b=%0d err_s=%0d", mcnt_b, merr_s);
        check_done("ovf");
        chk("ovf_err_sticky_s", err_s, 1'b1);
        chk("ovf_cnt_const_s", cnt_s, 1);
        fetch_chk("ovf_m3", 32'hC);
        chk("ovf_m3_const_s", rd_s, 32'h1122_3344);
        rom_addr = 32'h0; #1;
        chk("ovf_m0_const_s", rd_s, 32'h3C01_0101);
        q = {8'h3C, 8'h01, 8'h01, 8'h01};
        do_load("ovf_clear", 0, q, 1);

        // Restart mid-word with a byte presented alongside ld_start
        do_start(0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        ld_start = 1'b1; ld_base = 10'd5; ld_valid = 1'b1; ld_byte = 8'h03; ld_last = 1'b0;
        step();
        ld_start = 1'b0; ld_valid = 1'b0;
        chk("restart_cnt_b", cnt_b, 0);
        chk("restart_busy_b", busy_b, 1'b1);
        q = {8'h0A, 8'h0B, 8'h0C, 8'h0D};
        for (int i = 0; i < 4; i++) send_byte(q[i], i == 3, 0);
        model_load(5, q);
        $display("LOAD restart base=5 bytes=4 words_b=%0d err_s=%0d", mcnt_b, merr_s);
        check_done("restart");
        rom_addr = 32'd20; #1;
        chk("restart_m5_const_b", rd_b, 32'h0A0B_0C0D);
        rom_addr = 32'd0; #1;
        chk("restart_m0_b", rd_b, 32'h3C01_0101);
        chk("restart_m0_s", rd_s, 32'h3C01_0101);

        // Reset mid-load
        do_start(0);
        q = {8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E};
        for (int i = 0; i < 5; i++) send_byte(q[i], 1'b0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mb[0] = 32'h5A5B_5C5D; ms[0] = 32'h5A5B_5C5D;
        $display("LOAD reset_mid base=0 bytes=5 (aborted)");
        chk("rstmid_busy_b", busy_b, 1'b0);
        chk("rstmid_busy_s", busy_s, 1'b0);
        chk("rstmid_cnt_b", cnt_b, 0);
        chk("rstmid_ready_b", rdy_b, 1'b0);
        rom_addr = 32'h0; #1;
        chk("rstmid_m0_b", rd_b, 32'h5A5B_5C5D);
        rom_addr = 32'h4; #1;
        chk("rstmid_m1_b", rd_b, 32'hAABB_CCDD);
        chk("rstmid_m1_s", rd_s, 32'h0A0B_0C0D);

        // Randomized loads checked against the model
        for (int t = 0; t < 25; t++) begin
            int base;
            int len;
            base = (($urandom_range(0, 3) == 0) ? 1020 + $urandom_range(0, 3)
                                                : $urandom_range(0, 1023));
            len = $urandom_range(1, 14);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            do_load($sformatf("rnd%0d", t), base, q, 2);
            for (int k = 0; k < (len + 3) / 4 && base + k < 1024; k++)
                fetch_chk($sformatf("rnd%0d_w%0d", t, k),
                          {20'($urandom), 10'(base + k), 2'($urandom)});
            for (int k = 0; k < 4; k++)
                fetch_chk($sformatf("rnd%0d_s%0d", t, k), {28'($urandom), 2'(k), 2'b00});
            rom_en = 1'b0; #1;
            chk("rnd_disabled_b", rd_b, 32'h0);
            rom_en = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction memory responder for the OpenMIPS core's fetch port. It returns the 32-bit instruction word addressed by `rom_addr` in the same cycle, so the IF/ID pipeline register can capture it at the next edge. It also contains a byte-serial program loader, with a valid/ready handshake and a state machine, that fills the memory from a host or testbench before or between runs. It sits outside the core, opposite `rom_addr_out` / `rom_en` / `rom_data_in`.

## Interface
- `ADDR_WIDTH`, default 10: word-address width; depth = 2^ADDR_WIDTH 32-bit words.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `rom_en` input 1: fetch enable from core.
- `rom_addr` input 32: byte address from core; word index = `rom_addr[ADDR_WIDTH+1:2]`.
- `rom_data` output 32: fetched instruction.
- `ld_start` input 1: begin (or restart) a load at `ld_base`.
- `ld_base` input ADDR_WIDTH: starting word index, sampled only when `ld_start` is high in IDLE, LOAD or DRAIN.
- `ld_valid` input 1: `ld_byte` is valid.
- `ld_byte` input 8: program byte, big-endian order (first byte goes to bits 31:24).
- `ld_last` input 1: qualifies the final byte of the image.
- `ld_ready` output 1: loader accepts a byte this cycle.
- `ld_busy` output 1: loader not IDLE.
- `ld_count` output ADDR_WIDTH+1: words written since the last `ld_start`.
- `ld_err` output 1: sticky overflow flag; cleared by `ld_start` or `reset`.

## Operation
- States: IDLE, LOAD, DRAIN. `ld_busy` = state != IDLE. `ld_ready` = LOAD or DRAIN.
- **IDLE** + `ld_start` → LOAD.
  - Word pointer `wptr` ← `ld_base`, byte index ← 0, assembly register ← 0.
  - `ld_count` ← 0, `ld_err` ← 0.
- **LOAD**: each accepted byte (`ld_valid & ld_ready`) is placed in lane `3 - idx`, then idx increments.
- **Word write** happens on the edge that accepts byte idx 3, or on the edge that accepts a byte with `ld_last`:
  - The assembled word, with unfilled lanes zero-padded, is written to `mem[wptr]`.
  - `ld_count` increments and idx resets to 0.
- **After a write**:
  - If `ld_last` was set → IDLE.
  - Else if `wptr` was 2^ADDR_WIDTH−1 → `ld_err` ← 1 and state → DRAIN.
  - Else `wptr` increments.
- **DRAIN**: accepts and discards bytes until one with `ld_last` is accepted, then → IDLE. No memory writes.
- **`ld_start` in LOAD or DRAIN**: restarts exactly as from IDLE. The partial word is discarded and any byte presented in the same cycle is ignored, because `ld_start` has priority.
- **`ld_valid` without `ld_start` in IDLE**: ignored.
- **Fetch**: `rom_data = mem[rom_addr[ADDR_WIDTH+1:2]]` when `rom_en & ~ld_busy & ~reset`, else 32'h0.
  - `rom_addr[1:0]` and bits above ADDR_WIDTH+1 are ignored (aliasing).
- **Reset**:
  - State → IDLE; `wptr`, idx, assembly register → 0.
  - `ld_count` 0, `ld_err` 0, `ld_ready` 0, `ld_busy` 0, `rom_data` 0.
  - The memory array is NOT cleared.

## Timing
- Fetch is combinational: `rom_data` is valid in the same cycle as `rom_addr` / `rom_en`. Zero-cycle latency.
- `ld_start` sampled at edge N → `ld_busy` = `ld_ready` = 1 from cycle N+1.
- One byte accepted per cycle maximum. Gaps in `ld_valid` are allowed; state and idx hold.
- A word written at edge N is readable via fetch from cycle N+1, once `ld_busy` is low.
- Final byte accepted at edge N → `ld_busy` = `ld_ready` = 0 in cycle N+1. `ld_count` is final at N+1.
- `ld_err` rises in the cycle after the write to the top entry. It stays high through DRAIN and IDLE until `ld_start` or `reset`.
- `ld_count` cannot overflow: it saturates naturally at 2^ADDR_WIDTH because of DRAIN.

## Test plan
- **Reset**: assert `reset` with `rom_en`=1.
  - `rom_data`=0, `ld_ready`=0, `ld_busy`=0, `ld_count`=0, `ld_err`=0.
  - Preloaded memory survives: after reset, a fetch returns the prior word.
- **Full-word load**: `ld_start`, `ld_base`=0, then bytes 3C 01 01 01 34 21 00 20 with `ld_last` on the 8th.
  - `ld_count`=2.
  - Fetch with `rom_addr`=0 → 32'h3C010101; `rom_addr`=4 → 32'h34210020; `rom_addr`=6 → 32'h34210020.
  - `rom_en`=0 → 0.
- **Partial word with gaps**: `ld_base`=1, bytes AA BB CC DD EE FF with `ld_valid` idle cycles between them, `ld_last` on FF.
  - mem[1]=32'hAABBCCDD, mem[2]=32'hEEFF0000, `ld_count`=2.
  - `ld_busy` is low the cycle after FF is accepted.
- **Overflow**: `ADDR_WIDTH`=2, `ld_base`=3, 8 bytes 11..88 with `ld_last` on 88.
  - mem[3]=32'h11223344, `ld_err`=1, bytes 55..88 accepted and dropped.
  - mem[0] unchanged, `ld_count`=1.
  - The next `ld_start` clears `ld_err`.
- **Restart mid-word**: `ld_base`=0, bytes 01 02, then `ld_start` with `ld_base`=5 while `ld_valid` is high with byte 03.
  - Byte 03 ignored, `ld_count`=0.
  - The following bytes 0A 0B 0C 0D with `ld_last` → mem[5]=32'h0A0B0C0D; mem[0] is not written.
- **Reset mid-load**: after 5 bytes at base 0, assert `reset` for 1 cycle.
  - State IDLE, `ld_busy`=0, `ld_count`=0.
  - mem[0] holds its first-word value; mem[1] is unchanged from before the load.
